fp16_to_int: RTL and testbench

//  Converts an IEEE754 half-precision value to a 16-bit two's-complement integer.

---
 rtl/fp16_to_int_if.sv | 27 ++
 rtl/fp16_to_int.sv | 165 ++++++++++++++++
 tb/tb_fp16_to_int.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fp16_to_int_if.sv
`default_nettype none
// ============================================================================
// Module   : fp16_to_int_if
// Purpose  : Handshake bundle for the fp16 -> int16 converter.
//            master : the producer side, which drives the operand and R_I
//            slave  : the converter side, which returns the result, R_O
//                     and REG_ERROR
// Signals  : dataIn[15:0]  fp16 operand {sign, exp[4:0], frac[9:0]}
//            R_I           operand valid
//            dataOut[15:0] signed integer result
//            R_O           one-cycle completion pulse
//            REG_ERROR     completion carries an illegal-conversion flag
// Revision : 1.0  initial release
// ============================================================================
interface fp16_to_int_if;
   logic [15:0] dataIn;
   logic        R_I;
   logic [15:0] dataOut;
   logic        R_O;
   logic        REG_ERROR;

   modport master (output dataIn, output R_I,
                   input  dataOut, input R_O, input REG_ERROR);
   modport slave  (input  dataIn, input R_I,
                   output dataOut, output R_O, output REG_ERROR);
endinterface
`default_nettype wire

// File: rtl/fp16_to_int.sv
`default_nettype none
// ============================================================================
// Module   : fp16_to_int
// Purpose  : Converts an IEEE754 half-precision operand into a 16-bit
//            two's-complement integer.  The mantissa is aligned by a
//            1-bit-per-cycle shifter, so latency depends on the exponent.
// Ports    : clk    rising-edge clock
//            reset  asynchronous active-low reset
//            bus    fp16_to_int_if.slave (dataIn, R_I in; dataOut, R_O,
//                   REG_ERROR out)
// Params   : MAX_MAG  largest legal result magnitude (default 2048)
// Macro    : FP16_ROUND_NEAREST_EN  when defined, round half away from zero;
//            otherwise truncate toward zero.
// Revision : 1.0  initial release
// ============================================================================
module fp16_to_int #(
   parameter int unsigned MAX_MAG = 2048
) (
   input  logic          clk,
   input  logic          reset,
   fp16_to_int_if.slave  bus
);

`ifdef FP16_ROUND_NEAREST_EN
   localparam logic ROUND_EN = 1'b1;
`else
   localparam logic ROUND_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      SHIFT = 3'd2,
      SIGN  = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] din_q,   din_d;
   logic [16:0] mag_q,   mag_d;    // 17 bits: 2047 << 5 = 65504 never wraps
   logic [3:0]  cnt_q,   cnt_d;
   logic        left_q,  left_d;
   logic        guard_q, guard_d;  // last bit shifted out (rounding only)
   logic [15:0] dout_q,  dout_d;
   logic        ro_q,    ro_d;
   logic        err_q,   err_d;

   logic [4:0]  w_exp;
   logic [16:0] w_mag_rnd;

   assign w_exp = din_q[14:10];
   // Guard is gated to zero in truncating builds.
   assign w_mag_rnd = mag_q + {16'd0, guard_q & ROUND_EN};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         din_q   <= '0;
         mag_q   <= '0;
         cnt_q   <= '0;
         left_q  <= 1'b0;
         guard_q <= 1'b0;
         dout_q  <= '0;
         ro_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         guard_q <= guard_d;
         dout_q  <= dout_d;
         ro_q    <= ro_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      din_d   = din_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      guard_d = guard_q;
      dout_d  = dout_q;
      ro_d    = ro_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            ro_d  = 1'b0;
            err_d = 1'b0;
            if (bus.R_I) begin
               din_d   = bus.dataIn;
               state_d = CHECK;
            end
         end

         CHECK: begin
            mag_d   = {6'd0, (w_exp != 5'd0), din_q[9:0]};
            guard_d = 1'b0;
            if (w_exp == 5'd31) begin
               state_d = ERR;
            end else if (w_exp < 5'd15) begin
               // |x| < 1 (includes zero/denormal); only e == -1 can round up.
               mag_d   = '0;
               cnt_d   = '0;
               guard_d = (w_exp == 5'd14);
               state_d = SIGN;
            end else if (w_exp <= 5'd25) begin
               // Binary point sits 10 - e bits into the mantissa.
               cnt_d   = 4'(5'd25 - w_exp);
               left_d  = 1'b0;
               state_d = (w_exp == 5'd25) ? SIGN : SHIFT;
            end else begin
               cnt_d   = 4'(w_exp - 5'd25);
               left_d  = 1'b1;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (left_q) begin
               mag_d = {mag_q[15:0], 1'b0};
            end else begin
               mag_d   = {1'b0, mag_q[16:1]};
               guard_d = mag_q[0];
            end
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = SIGN;
            end
         end

         SIGN: begin
            // Range is judged on the rounded magnitude, never on overflow.
            if ({15'd0, w_mag_rnd} > MAX_MAG) begin
               state_d = ERR;
            end else begin
               dout_d  = din_q[15] ? (16'd0 - w_mag_rnd[15:0]) : w_mag_rnd[15:0];
               ro_d    = 1'b1;
               state_d = IDLE;
            end
         end

         ERR: begin
            dout_d  = '0;
            err_d   = 1'b1;
            ro_d    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.dataOut   = dout_q;
   assign bus.R_O       = ro_q;
   assign bus.REG_ERROR = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_to_int.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_to_int
// Purpose  : Self-checking bench for fp16_to_int.  A driver issues operands
//            and pushes the expected result/latency into a queue; a monitor
//            pops and compares whenever R_O is seen.
// Macro    : FP16_ROUND_NEAREST_EN selects the rounding reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp16_to_int;

`ifdef FP16_ROUND_NEAREST_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   typedef struct {
      logic [15:0] din;
      logic [15:0] dout;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;

   logic clk;
   logic reset;
   fp16_to_int_if bus();

   fp16_to_int #(.MAX_MAG(2048)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: value = mant * 2^(e-10), range-checked against 2048.
   function automatic void model(input logic [15:0] x, output logic [15:0] dout,
                                 output logic err, output int lat);
      int ex, e, mant, mag;
      ex   = int'(x[14:10]);
      e    = ex - 15;
      mant = (ex != 0 ? 1024 : 0) + int'(x[9:0]);
      lat  = 2;
      if (ex == 31) begin
         dout = 16'h0000;
         err  = 1'b1;
         return;
      end
      if (ex == 0 || e < 0) begin
         mag = (ROUND && e == -1) ? 1 : 0;
      end else if (e <= 10) begin
         lat = 2 + (10 - e);
         if (ROUND && e < 10) mag = (mant + (1 << (9 - e))) >> (10 - e);
         else                 mag = mant >> (10 - e);
      end else begin
         lat = 2 + (e - 10);
         mag = mant << (e - 10);
      end
      if (mag > 2048) begin
         dout = 16'h0000;
         err  = 1'b1;
         lat  = lat + 1;
      end else begin
         dout = x[15] ? 16'(-mag) : 16'(mag);
         err  = 1'b0;
      end
   endfunction

   // Monitor: samples 1 time unit after every rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         if (bus.R_O === 1'b1) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_R_O cycle=%0d dataOut=%h required no R_O", cyc, bus.dataOut);
            end else begin
               e = q.pop_front();
               checks++;
               if (bus.dataOut !== e.dout) begin
                  failures++;
                  $display("FAIL dataOut in=%h actual=%h required=%h", e.din, bus.dataOut, e.dout);
               end
               checks++;
               if (bus.REG_ERROR !== e.err) begin
                  failures++;
                  $display("FAIL REG_ERROR in=%h actual=%b required=%b", e.din, bus.REG_ERROR, e.err);
               end
               checks++;
               if (cyc - e.acc != e.lat) begin
                  failures++;
                  $display("FAIL latency in=%h actual=%0d required=%0d", e.din, cyc - e.acc, e.lat);
               end
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after completion.
   task automatic issue(input logic [15:0] x, input bit busy_pulse);
      exp_t e;
      logic [15:0] d;
      logic        er;
      int          l;
      model(x, d, er, l);
      e.din = x; e.dout = d; e.err = er; e.lat = l; e.acc = cyc + 1;
      q.push_back(e);
      bus.dataIn = x;
      bus.R_I    = 1'b1;
      @(negedge clk);
      if (busy_pulse) begin
         // DUT is in CHECK here; this operand must be ignored.
         bus.dataIn = 16'($urandom);
         @(negedge clk);
      end
      bus.R_I    = 1'b0;
      bus.dataIn = 16'($urandom);
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++; failures++;
         $display("FAIL timeout in=%h no R_O within 60 cycles", x);
         q.delete();
      end
   endtask

   logic [15:0] dir_vec [16] = '{16'h4000, 16'hE800, 16'h6801, 16'h7C00,
                                 16'h7E00, 16'h3E00, 16'hBE00, 16'h8000,
                                 16'h0001, 16'h3400, 16'h3800, 16'h6800,
                                 16'h7BFF, 16'hFBFF, 16'h3C00, 16'h6400};

   initial begin
      logic [15:0] x;
      reset      = 1'b0;
      bus.R_I    = 1'b0;
      bus.dataIn = 16'h0000;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.dataOut !== 16'h0000 || bus.R_O !== 1'b0 || bus.REG_ERROR !== 1'b0) begin
         failures++;
         $display("FAIL reset_state actual=%h/%b/%b required=0000/0/0",
                  bus.dataOut, bus.R_O, bus.REG_ERROR);
      end
      reset = 1'b1;
      @(negedge clk);

      foreach (dir_vec[i]) issue(dir_vec[i], (i % 3) == 1);

      // Abort a conversion of 2.0 in the middle of its shift phase.
      issue(16'h4000, 1'b0);
      bus.dataIn = 16'h4000;
      bus.R_I    = 1'b1;
      @(negedge clk);
      bus.R_I    = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus.dataOut !== 16'h0000 || bus.R_O !== 1'b0 || bus.REG_ERROR !== 1'b0) begin
         failures++;
         $display("FAIL async_reset actual=%h/%b/%b required=0000/0/0",
                  bus.dataOut, bus.R_O, bus.REG_ERROR);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);

      for (int n = 0; n < 150; n++) begin
         x = 16'($urandom);
         if ($urandom_range(0, 1) == 1) x[14:10] = 5'($urandom_range(13, 27));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(x, $urandom_range(0, 3) == 0);
      end

      repeat (5) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expectations actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
